// File: rtl/rtio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtio_pkg
//  Description : Shared constants and helpers for the real-time I/O channel
//                ports (timestamp/channel widths, occupancy-count width).
//  Revision    : 1.0 - initial release
// ============================================================================
package rtio_pkg;

    localparam int DEFAULT_TIMESTAMP_WIDTH = 64;
    localparam int DEFAULT_CHANNEL_LENGTH  = 12;

    // Bits needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timed_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : timed_event_fifo
//  Description : Synchronous FIFO holding {timestamp, data} events. The head
//                entry is presented combinationally from registered storage.
//                full/empty/count are registered and track the state after
//                the last edge. Flush empties the FIFO and beats push/pop.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                flush           - discard all entries
//                push, wr_data   - enqueue request (ignored when full)
//                pop             - dequeue request (ignored when empty)
//                rd_data         - head entry
//                full, empty     - registered status
//                count           - registered occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module timed_event_fifo
    import rtio_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16   // power of two, >= 2
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wr_data,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] w_count_next;
    logic             w_do_push;
    logic             w_do_pop;

    // full/empty come from the previous edge, so a push while full is
    // dropped even when the same cycle pops.
    assign w_do_push = push && !full  && !flush;
    assign w_do_pop  = pop  && !empty && !flush;

    always_comb begin
        w_count_next = count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_count_next = count + CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // DEPTH is a power of two, so natural overflow wraps the pointers.
                if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            count <= w_count_next;
            full  <= (w_count_next == CNT_W'(DEPTH));
            empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/timed_output_port.sv
`default_nettype none
// ============================================================================
//  Module      : timed_output_port
//  Description : Timestamp-scheduled output port. Writes addressed to
//                DEST_VAL are queued as {timestamp, data}; the head entry is
//                applied to data_out once the global counter reaches its
//                timestamp. Sticky flags report dropped and late events.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                wr_en, dest_in,
//                timestamp_in, data_in      - channel write bus
//                counter                    - global timestamp
//                flush                      - discard queued events
//                clear_error                - clear sticky error flags
//                data_out                   - registered output value
//                full, empty, fifo_count    - queue status
//                overflow_error, late_error - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module timed_output_port
    import rtio_pkg::*;
#(
    parameter int NUM_DATA        = 1,
    parameter int DEST_VAL        = 0,
    parameter int CHANNEL_LENGTH  = DEFAULT_CHANNEL_LENGTH,
    parameter int TIMESTAMP_WIDTH = DEFAULT_TIMESTAMP_WIDTH,
    parameter int FIFO_DEPTH      = 16
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [CHANNEL_LENGTH-1:0]          dest_in,
    input  logic [TIMESTAMP_WIDTH-1:0]         timestamp_in,
    input  logic [NUM_DATA-1:0]                data_in,
    input  logic [TIMESTAMP_WIDTH-1:0]         counter,
    input  logic                               flush,
    input  logic                               clear_error,
    output logic [NUM_DATA-1:0]                data_out,
    output logic                               full,
    output logic                               empty,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
    output logic                               overflow_error,
    output logic                               late_error
);

    localparam int ENTRY_W = TIMESTAMP_WIDTH + NUM_DATA;

    logic                       w_accept;
    logic                       w_overflow;
    logic                       w_issue;
    logic                       w_late;
    logic [ENTRY_W-1:0]         w_head;
    logic [TIMESTAMP_WIDTH-1:0] w_head_ts;
    logic [NUM_DATA-1:0]        w_head_data;

    assign w_accept = wr_en && (dest_in == CHANNEL_LENGTH'(DEST_VAL));

    timed_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (w_accept),
        .pop     (w_issue),
        .wr_data ({timestamp_in, data_in}),
        .rd_data (w_head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign w_head_ts   = w_head[ENTRY_W-1:NUM_DATA];
    assign w_head_data = w_head[NUM_DATA-1:0];

    // A write discarded by flush is not an overflow.
    assign w_overflow = w_accept && full && !flush;

    // Plain unsigned compare: the counter is wide enough never to wrap.
    assign w_issue = !empty && (w_head_ts <= counter) && !flush;
    assign w_late  = w_issue && (w_head_ts < counter);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            overflow_error <= 1'b0;
            late_error     <= 1'b0;
        end else begin
            if (w_issue) data_out <= w_head_data;

            // A new error in the clearing cycle must not be lost.
            if (w_overflow)       overflow_error <= 1'b1;
            else if (clear_error) overflow_error <= 1'b0;

            if (w_late)           late_error <= 1'b1;
            else if (clear_error) late_error <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timed_output_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timed_output_port
//  Description : Directed self-checking bench for timed_output_port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timed_output_port;

    localparam int NUM_DATA   = 4;
    localparam int DEST_VAL   = 3;
    localparam int CH_LEN     = 12;
    localparam int TS_W       = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [CH_LEN-1:0] dest_in = '0;
    logic [TS_W-1:0]   timestamp_in = '0;
    logic [NUM_DATA-1:0] data_in = '0;
    logic [TS_W-1:0]   counter = '0;
    logic              flush = 1'b0;
    logic              clear_error = 1'b0;
    logic [NUM_DATA-1:0] data_out;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow_error;
    logic              late_error;

    int n_cmp = 0;
    int n_err = 0;
    logic [NUM_DATA-1:0] exp_q [$];
    logic [NUM_DATA-1:0] last_out;

    timed_output_port #(
        .NUM_DATA        (NUM_DATA),
        .DEST_VAL        (DEST_VAL),
        .CHANNEL_LENGTH  (CH_LEN),
        .TIMESTAMP_WIDTH (TS_W),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .dest_in        (dest_in),
        .timestamp_in   (timestamp_in),
        .data_in        (data_in),
        .counter        (counter),
        .flush          (flush),
        .clear_error    (clear_error),
        .data_out       (data_out),
        .full           (full),
        .empty          (empty),
        .fifo_count     (fifo_count),
        .overflow_error (overflow_error),
        .late_error     (late_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the counter advances as the global timestamp does.
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 64'd1;
    endtask

    task automatic write(input logic [CH_LEN-1:0] d, input logic [TS_W-1:0] ts,
                         input logic [NUM_DATA-1:0] v);
        wr_en = 1'b1; dest_in = d; timestamp_in = ts; data_in = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_next(input string tag);
        logic [NUM_DATA-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, data_out);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(data_out), 64'(e));
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_empty",    64'(empty), 64'd1);
        check("rst_full",     64'(full), 64'd0);
        check("rst_count",    64'(fifo_count), 64'd0);
        check("rst_ovf",      64'(overflow_error), 64'd0);
        check("rst_late",     64'(late_error), 64'd0);

        // ---------------- decode: wrong address ignored ----------------
        write(CH_LEN'(DEST_VAL + 1), 64'd5, 4'd1);
        check("dec_empty", 64'(empty), 64'd1);
        check("dec_count", 64'(fifo_count), 64'd0);
        tick();
        check("dec_data_out", 64'(data_out), 64'd0);

        // ---------------- on-time event ----------------
        counter = 64'd10;
        exp_q.push_back(4'd1);
        write(CH_LEN'(DEST_VAL), 64'd20, 4'd1);
        check("ontime_count", 64'(fifo_count), 64'd1);
        while (counter != 64'd20) begin
            check("ontime_wait", 64'(data_out), 64'd0);
            tick();
        end
        check("ontime_before", 64'(data_out), 64'd0);
        tick();                                // edge that samples counter==20
        check_next("ontime_apply");
        check("ontime_late", 64'(late_error), 64'd0);
        check("ontime_empty", 64'(empty), 64'd1);

        // ---------------- late event ----------------
        counter = 64'd100;
        exp_q.push_back(4'd5);
        write(CH_LEN'(DEST_VAL), 64'd50, 4'd5);
        check("late_one_edge", 64'(data_out), 64'd1);
        tick();
        check_next("late_apply");
        check("late_flag", 64'(late_error), 64'd1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("late_clear", 64'(late_error), 64'd0);

        // ---------------- overflow and pointer wrap ----------------
        counter = 64'd200;
        for (int i = 0; i < 17; i++) begin
            if (i < FIFO_DEPTH) exp_q.push_back(NUM_DATA'(15 - i));
            write(CH_LEN'(DEST_VAL), 64'd1000 + 64'(i), NUM_DATA'(15 - i));
        end
        check("ovf_full",  64'(full), 64'd1);
        check("ovf_count", 64'(fifo_count), 64'd16);
        check("ovf_flag",  64'(overflow_error), 64'd1);
        check("ovf_no_late", 64'(late_error), 64'd0);
        counter = 64'd1000;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            tick();
            check_next("drain_order");
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_late",  64'(late_error), 64'd0);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("ovf_clear", 64'(overflow_error), 64'd0);

        // ---------------- overdue backlog ----------------
        counter = 64'd25;
        exp_q.push_back(4'd1); exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        write(CH_LEN'(DEST_VAL), 64'd30, 4'd1);
        write(CH_LEN'(DEST_VAL), 64'd31, 4'd0);
        write(CH_LEN'(DEST_VAL), 64'd32, 4'd1);
        check("backlog_hold", 64'(data_out), 64'd0);   // last drained value was 0
        check("backlog_count", 64'(fifo_count), 64'd3);
        counter = 64'd40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_next("backlog_order");
        end
        check("backlog_late",  64'(late_error), 64'd1);
        check("backlog_empty", 64'(empty), 64'd1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;

        // ---------------- flush ----------------
        counter = 64'd500;
        for (int i = 0; i < 4; i++) write(CH_LEN'(DEST_VAL), 64'd5000, NUM_DATA'(3 + i));
        check("flush_pre_count", 64'(fifo_count), 64'd4);
        last_out = data_out;
        flush = 1'b1;
        write(CH_LEN'(DEST_VAL), 64'd5000, 4'd7);
        flush = 1'b0;
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_data",  64'(data_out), 64'(last_out));
        check("flush_ovf",   64'(overflow_error), 64'd0);
        check("flush_late",  64'(late_error), 64'd0);
        // FIFO keeps working after flush: minimum two-edge latency, on time.
        exp_q.push_back(4'd10);
        write(CH_LEN'(DEST_VAL), counter + 64'd1, 4'd10);
        tick();
        check_next("post_flush_apply");
        check("post_flush_late", 64'(late_error), 64'd0);

        // ---------------- mid-stream reset ----------------
        for (int i = 0; i < 4; i++) write(CH_LEN'(DEST_VAL), 64'd9000, NUM_DATA'(i + 1));
        reset = 1'b1;
        write(CH_LEN'(DEST_VAL), 64'd9000, 4'd9);
        reset = 1'b0;
        check("mrst_data",  64'(data_out), 64'd0);
        check("mrst_empty", 64'(empty), 64'd1);
        check("mrst_count", 64'(fifo_count), 64'd0);
        check("mrst_full",  64'(full), 64'd0);
        tick();
        check("mrst_stays", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
